// File: rtl/branch_resolve.sv
// Resolves EX-stage control transfers against the fetch prediction, raises redirects,
// squashes the wrong path for FLUSH_CYCLES after a redirect, and keeps perf counters.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        stall_in,
  output logic        branch_flag,
  output logic        branch_taken,
  output logic [31:0] branch_pc,
  output logic [31:0] branch_to,
  output logic        jump_flag,
  output logic        flush,
  output logic        link_valid,
  output logic [31:0] link_data,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLT  = 3'd2;
  localparam logic [2:0] OP_BGE  = 3'd3;
  localparam logic [2:0] OP_BLTU = 3'd4;
  localparam logic [2:0] OP_BGEU = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;

  logic        w_accept;
  logic        w_taken;
  logic        w_is_jump;
  logic        w_mispredict;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  // jump_flag is only ever high while already in FLUSH; kept explicit for clarity.
  assign w_accept = ex_valid && !stall_in && (r_state == ST_IDLE) && !jump_flag;

  always_comb begin
    w_taken    = 1'b0;
    w_is_jump  = 1'b0;
    w_pc_plus4 = ex_pc + 32'd4;
    case (ex_op)
      OP_BEQ:  w_taken = (ex_rs1 == ex_rs2);
      OP_BNE:  w_taken = (ex_rs1 != ex_rs2);
      OP_BLT:  w_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      OP_BGE:  w_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      OP_BLTU: w_taken = (ex_rs1 <  ex_rs2);
      OP_BGEU: w_taken = (ex_rs1 >= ex_rs2);
      OP_JAL,
      OP_JALR: begin
        w_taken   = 1'b1;
        w_is_jump = 1'b1;
      end
      default: w_taken = 1'b0;
    endcase
    if (ex_op == OP_JALR) begin
      w_target = (ex_rs1 + ex_imm) & ~32'd1;
    end else begin
      w_target = ex_pc + ex_imm;
    end
    w_next_pc    = w_taken ? w_target : w_pc_plus4;
    w_mispredict = (w_taken != ex_pred_taken) ||
                   (w_taken && (w_target != ex_pred_target));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_cnt            <= 4'd0;
      branch_flag      <= 1'b0;
      branch_taken     <= 1'b0;
      branch_pc        <= 32'd0;
      branch_to        <= 32'd0;
      jump_flag        <= 1'b0;
      flush            <= 1'b0;
      link_valid       <= 1'b0;
      link_data        <= 32'd0;
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else begin
      branch_flag <= w_accept;
      jump_flag   <= w_accept && w_mispredict;
      link_valid  <= w_accept && w_is_jump;

      if (w_accept) begin
        branch_taken  <= w_taken;
        branch_pc     <= ex_pc;
        branch_to     <= w_next_pc;
        perf_branches <= perf_branches + 32'd1;
        if (w_is_jump) begin
          link_data <= w_pc_plus4;
        end
      end

      // Counter runs FLUSH_LOAD..0 so flush covers the redirect cycle plus FLUSH_CYCLES more.
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_mispredict) begin
            r_state          <= ST_FLUSH;
            r_cnt            <= FLUSH_LOAD;
            flush            <= 1'b1;
            perf_mispredicts <= perf_mispredicts + 32'd1;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
            flush   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          flush   <= 1'b0;
        end
      endcase
    end
  end

endmodule
